residual_sequencer: RTL and testbench
=====================================

# residual_sequencer

Controller that sequences one subframe's residual decode in the FLAC pipeline. It owns the single residual RAM read port. It fetches and validates the residual header word, configures and releases `ResidualDecoder`, and counts decoded residuals to the required total. Between subframes it grants the read port to a host/inspection requester.

## Interface
Parameters:
- `ADDR_W`, 16: RAM read address width.
- `START_BIT`, 5'd9: bit index of the first Rice parameter bit in the header word; drives the decoder's `iStartBit`.

Ports (name, direction, width, meaning):
- `iClock` in 1: sole clock, rising edge.
- `iReset` in 1: asynchronous, active-low reset.
- `iStart` in 1: one-cycle pulse, begin subframe; honoured only in IDLE.
- `iAbort` in 1: abandon the current subframe.
- `iBaseAddr` in ADDR_W: address of the residual header word.
- `iBlockSize` in 16: samples in the block.
- `iPredictorOrder` in 4: warm-up samples; these are not residuals.
- `iHostReq` in 1: host requests the read port.
- `iHostAddr` in ADDR_W: host read address.
- `oHostGrant` out 1: host owns the port this cycle.
- `oRamReadAddr` out ADDR_W: RAM `rdaddress`.
- `iRamData` in 16: RAM `q`, valid 1 cycle after the address.
- `oDecReset` out 1: to the decoder `iReset` (active-high).
- `oDecEnable` out 1: to the decoder `iEnable`.
- `oDecPartitionOrder` out 4: latched header bits [13:10].
- `oDecPredictorOrder` out 4: latched `iPredictorOrder`.
- `oDecBlockSize` out 16: latched `iBlockSize`.
- `oDecStartAddr` out ADDR_W: `iBaseAddr + 1`.
- `iDecReadAddr` in ADDR_W: decoder `oReadAddr`.
- `iDecResidual` in 16 signed: decoder `oResidual`.
- `iDecDone` in 1: decoder per-sample strobe.
- `oResidual` out 16 signed: residual, registered.
- `oValid` out 1: `oResidual` valid.
- `oDone` out 1: one-cycle pulse, subframe complete.
- `oError` out 1: sticky until the next accepted `iStart`.
- `oBusy` out 1: the state is not IDLE.

## Operation
- States: IDLE, FETCH, LATCH, RUN, DONE, ERR.
- IDLE → FETCH on `iStart`.
  - Latch `iBaseAddr`, `iBlockSize` and `iPredictorOrder`.
  - Clear `oError`.
- FETCH: drive `oRamReadAddr = base`, then go to LATCH.
- LATCH: `iRamData` holds the header word.
  - method = [15:14]; porder = [13:10].
  - Error if method ≠ 2'b00 (only 4-bit Rice is supported).
  - Error if `BlockSize[porder-1:0]` ≠ 0.
  - Error if `(BlockSize >> porder) <= PredictorOrder`.
  - Any error → ERR; otherwise → RUN.
- RUN:
  - `oDecReset` = 0 and `oDecEnable` = 1.
  - `oRamReadAddr = iDecReadAddr`.
  - Each `iDecDone` registers `iDecResidual` to `oResidual`, pulses `oValid`, and increments a 16-bit count.
  - When count reaches `BlockSize − PredictorOrder`, go to DONE.
  - Done strobes after the terminal count are ignored.
- DONE: pulse `oDone` for one cycle, then → IDLE.
- ERR: pulse `oError` high; it stays high. Go → IDLE next cycle.
- `iAbort` in any non-IDLE state → IDLE next edge. No `oDone`, no `oValid`.
- Port arbitration:
  - `oHostGrant = iHostReq && state == IDLE`.
  - When granted, `oRamReadAddr = iHostAddr`.
  - `iStart` and `iHostReq` in the same IDLE cycle: `iStart` wins, and grant drops on the next edge.
- The decoder is held in reset (`oDecReset` = 1, `oDecEnable` = 0) in every state except RUN.

## Timing
- Reset values:
  - state IDLE.
  - `oDecReset` 1; `oDecEnable`, `oValid`, `oDone`, `oError`, `oBusy` 0.
  - `oResidual`, `oRamReadAddr` and the latched config 0.
  - `oHostGrant` follows `iHostReq`.
- `iStart` at edge N: FETCH at N+1, LATCH at N+2, RUN at N+3 (decoder first enabled).
- `oValid` follows `iDecDone` by 1 cycle.
- `oDone` asserts the cycle after the final `oValid`.
- `oRamReadAddr` is combinational from state and the muxed sources; the RAM registers it.
- Reset asserted mid-RUN: all outputs return to reset values immediately, with no `oDone`.
- The count is compared against the latched total; `iBlockSize` changing mid-run has no effect.

## Structure
- Shared package:
  - state enum.
  - `RES_METHOD_RICE4` = 2'b00, `RES_METHOD_RICE5` = 2'b01.
  - header field positions (method [15:14], porder [13:10]).
  - `START_BIT`.
- One natural sub-module: `residual_ram_port_mux` (three-way address mux plus grant logic).
- `ResidualDecoder` is a sibling instance and is not contained in this block.

## Test plan
- Header 0x29A5 at base 0, block 4096, order 0:
  - `oDecPartitionOrder` = 10, `oDecStartAddr` = 1.
  - Exactly 4096 `oValid`; first four residuals −6, 18, −56, −96.
  - `oDone` once.
- Header 0x69A5 (method 01): `oError` = 1 at RUN-equivalent cycle. No decoder enable, no `oValid`.
- Block 4096, porder 10, order 5 (4 ≤ 5): `oError`. Block 4095, porder 1: `oError`.
- `iAbort` after 100 valids: IDLE next cycle, `oDecReset` = 1, no `oDone`. A fresh `iStart` completes normally.
- `iHostReq` with `iHostAddr` 0x0123 in IDLE: grant, `oRamReadAddr` = 0x0123. Simultaneous `iStart`: FETCH wins, `oRamReadAddr` = base, grant 0 from N+1.
- `iReset` low mid-RUN: all outputs at reset values asynchronously, `oBusy` 0.

Source files
------------

// File: rtl/residual_sequencer_pkg.sv
// Shared types and constants for the residual sequencer: state encoding,
// residual header field layout and the header validation helper.
package residual_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } seq_state_t;

    localparam logic [1:0] RES_METHOD_RICE4 = 2'b00;
    localparam logic [1:0] RES_METHOD_RICE5 = 2'b01;

    localparam int unsigned HDR_METHOD_MSB = 15;
    localparam int unsigned HDR_METHOD_LSB = 14;
    localparam int unsigned HDR_PORDER_MSB = 13;
    localparam int unsigned HDR_PORDER_LSB = 10;

    localparam logic [4:0] START_BIT = 5'd9;

    // Block must split evenly into 2^porder partitions, and the first
    // partition must hold more samples than the warm-up samples it loses.
    function automatic logic partition_ok(input logic [15:0] block_size,
                                          input logic [3:0]  porder,
                                          input logic [3:0]  pred_order);
        logic [15:0] mask;
        mask = (16'd1 << porder) - 16'd1;
        return ((block_size & mask) == '0) &&
               ((block_size >> porder) > {12'd0, pred_order});
    endfunction

endpackage

// File: rtl/residual_ram_port_mux.sv
// Residual RAM read-address selection between header fetch, the decoder
// and the host requester, plus the host grant.
module residual_ram_port_mux
    import residual_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  seq_state_t        state,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              grant,
    output logic [ADDR_W-1:0] addr
);

    always_comb begin
        grant = host_req && (state == ST_IDLE);
        addr  = '0;
        case (state)
            ST_IDLE:  if (host_req) addr = host_addr;
            ST_FETCH: addr = base_addr;
            ST_RUN:   addr = dec_addr;
            default:  addr = '0;
        endcase
    end

endmodule

// File: rtl/residual_sequencer.sv
// Sequences one subframe's residual decode: header fetch and validation,
// decoder release, residual counting and read-port arbitration.
module residual_sequencer
    import residual_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter logic [4:0]  START_BIT = residual_sequencer_pkg::START_BIT
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iStart,
    input  logic                iAbort,
    input  logic [ADDR_W-1:0]   iBaseAddr,
    input  logic [15:0]         iBlockSize,
    input  logic [3:0]          iPredictorOrder,
    input  logic                iHostReq,
    input  logic [ADDR_W-1:0]   iHostAddr,
    output logic                oHostGrant,
    output logic [ADDR_W-1:0]   oRamReadAddr,
    input  logic [15:0]         iRamData,
    output logic                oDecReset,
    output logic                oDecEnable,
    output logic [4:0]          oDecStartBit,
    output logic [3:0]          oDecPartitionOrder,
    output logic [3:0]          oDecPredictorOrder,
    output logic [15:0]         oDecBlockSize,
    output logic [ADDR_W-1:0]   oDecStartAddr,
    input  logic [ADDR_W-1:0]   iDecReadAddr,
    input  logic signed [15:0]  iDecResidual,
    input  logic                iDecDone,
    output logic signed [15:0]  oResidual,
    output logic                oValid,
    output logic                oDone,
    output logic                oError,
    output logic                oBusy
);

    seq_state_t         state, next_state;
    logic [ADDR_W-1:0]  base_q;
    logic [ADDR_W-1:0]  start_addr_q;
    logic [15:0]        block_size_q;
    logic [3:0]         pred_order_q;
    logic [3:0]         porder_q;
    logic [15:0]        count_q;
    logic signed [15:0] residual_q;
    logic               valid_q;
    logic               done_q;
    logic               error_q;

    logic [1:0]         hdr_method;
    logic [3:0]         hdr_porder;
    logic               hdr_ok;
    logic [15:0]        total;
    logic               run_strobe;
    logic               unused_hdr_bits;

    assign hdr_method      = iRamData[HDR_METHOD_MSB:HDR_METHOD_LSB];
    assign hdr_porder      = iRamData[HDR_PORDER_MSB:HDR_PORDER_LSB];
    assign unused_hdr_bits = ^iRamData[HDR_PORDER_LSB-1:0];
    assign hdr_ok          = (hdr_method == RES_METHOD_RICE4) &&
                             partition_ok(block_size_q, hdr_porder, pred_order_q);
    assign total           = block_size_q - {12'd0, pred_order_q};
    assign run_strobe      = (state == ST_RUN) && iDecDone && !iAbort;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (iStart) next_state = ST_FETCH;
            ST_FETCH: next_state = ST_LATCH;
            ST_LATCH: next_state = hdr_ok ? ST_RUN : ST_ERR;
            ST_RUN:   if (iDecDone && (count_q + 16'd1 == total)) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            ST_ERR:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
        if (iAbort && (state != ST_IDLE)) next_state = ST_IDLE;
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            base_q       <= '0;
            start_addr_q <= '0;
            block_size_q <= '0;
            pred_order_q <= '0;
            porder_q     <= '0;
            count_q      <= '0;
            residual_q   <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && iStart) begin
                base_q       <= iBaseAddr;
                start_addr_q <= iBaseAddr + ADDR_W'(1);
                block_size_q <= iBlockSize;
                pred_order_q <= iPredictorOrder;
                count_q      <= '0;
                error_q      <= 1'b0;
            end
            if (state == ST_LATCH) porder_q <= hdr_porder;
            // Set on the LATCH->ERR edge so the flag is visible in the ERR cycle.
            if ((state == ST_LATCH) && (next_state == ST_ERR)) error_q <= 1'b1;
            if (run_strobe) begin
                residual_q <= iDecResidual;
                count_q    <= count_q + 16'd1;
            end
            valid_q <= run_strobe;
            done_q  <= (state == ST_DONE) && !iAbort;
        end
    end

    residual_ram_port_mux #(
        .ADDR_W (ADDR_W)
    ) u_port_mux (
        .state     (state),
        .base_addr (base_q),
        .dec_addr  (iDecReadAddr),
        .host_req  (iHostReq),
        .host_addr (iHostAddr),
        .grant     (oHostGrant),
        .addr      (oRamReadAddr)
    );

    assign oDecReset          = (state != ST_RUN);
    assign oDecEnable         = (state == ST_RUN);
    assign oDecStartBit       = START_BIT;
    assign oDecPartitionOrder = porder_q;
    assign oDecPredictorOrder = pred_order_q;
    assign oDecBlockSize      = block_size_q;
    assign oDecStartAddr      = start_addr_q;
    assign oResidual          = residual_q;
    assign oValid             = valid_q;
    assign oDone              = done_q;
    assign oError             = error_q;
    assign oBusy              = (state != ST_IDLE);

endmodule

// File: tb/tb_residual_sequencer.sv
// Directed bench for residual_sequencer with a one-cycle-latency RAM model
// and the decoder strobes driven directly.
module tb_residual_sequencer;

    localparam int unsigned ADDR_W = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start, abort_req;
    logic [ADDR_W-1:0]  base_addr;
    logic [15:0]        block_size;
    logic [3:0]         pred_order;
    logic               host_req;
    logic [ADDR_W-1:0]  host_addr;
    logic               host_grant;
    logic [ADDR_W-1:0]  ram_addr;
    logic [15:0]        ram_q;
    logic               dec_reset, dec_enable;
    logic [4:0]         dec_start_bit;
    logic [3:0]         dec_porder, dec_pred;
    logic [15:0]        dec_bs;
    logic [ADDR_W-1:0]  dec_start_addr;
    logic [ADDR_W-1:0]  dec_read_addr;
    logic signed [15:0] dec_residual;
    logic               dec_done;
    logic signed [15:0] residual;
    logic               valid, done, error, busy;

    logic [15:0] mem [0:255];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= mem[ram_addr[7:0]];

    residual_sequencer #(
        .ADDR_W    (ADDR_W),
        .START_BIT (5'd9)
    ) dut (
        .iClock             (clk),
        .iReset             (rst_n),
        .iStart             (start),
        .iAbort             (abort_req),
        .iBaseAddr          (base_addr),
        .iBlockSize         (block_size),
        .iPredictorOrder    (pred_order),
        .iHostReq           (host_req),
        .iHostAddr          (host_addr),
        .oHostGrant         (host_grant),
        .oRamReadAddr       (ram_addr),
        .iRamData           (ram_q),
        .oDecReset          (dec_reset),
        .oDecEnable         (dec_enable),
        .oDecStartBit       (dec_start_bit),
        .oDecPartitionOrder (dec_porder),
        .oDecPredictorOrder (dec_pred),
        .oDecBlockSize      (dec_bs),
        .oDecStartAddr      (dec_start_addr),
        .iDecReadAddr       (dec_read_addr),
        .iDecResidual       (dec_residual),
        .iDecDone           (dec_done),
        .oResidual          (residual),
        .oValid             (valid),
        .oDone              (done),
        .oError             (error),
        .oBusy              (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [15:0] res_val(input int unsigned i);
        case (i)
            0:       return -16'sd6;
            1:       return 16'sd18;
            2:       return -16'sd56;
            3:       return -16'sd96;
            default: return 16'(i);
        endcase
    endfunction

    // Ends in the cycle where the sequencer is in RUN or ERR.
    task automatic start_sub(input logic [15:0] base, input logic [15:0] bs, input logic [3:0] po);
        base_addr  = base;
        block_size = bs;
        pred_order = po;
        start      = 1'b1;
        tick;
        start      = 1'b0;
        tick;
        tick;
    endtask

    task automatic feed(input int unsigned n, output int unsigned valids);
        valids = 0;
        for (int unsigned i = 0; i < n; i++) begin
            dec_done     = 1'b1;
            dec_residual = res_val(i);
            tick;
            if (valid === 1'b1) valids++;
        end
        dec_done = 1'b0;
    endtask

    initial begin
        int unsigned valids;
        int unsigned dones;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]     = 16'h29A5;
        mem[8]     = 16'h69A5;
        mem[16]    = 16'h0400;
        mem[24]    = 16'h0C00;
        mem[32]    = 16'h0800;
        mem[8'h40] = 16'h0800;

        rst_n = 1'b0; start = 1'b0; abort_req = 1'b0;
        base_addr = '0; block_size = '0; pred_order = '0;
        host_req = 1'b0; host_addr = 16'h0123;
        dec_read_addr = '0; dec_residual = '0; dec_done = 1'b0;

        // Reset values
        #3;
        chk("rst_dec_reset", 32'(dec_reset), 32'd1);
        chk("rst_dec_enable", 32'(dec_enable), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_residual", 32'(residual), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_grant_lo", 32'(host_grant), 32'd0);
        chk("rst_porder", 32'(dec_porder), 32'd0);
        chk("rst_bs", 32'(dec_bs), 32'd0);
        chk("rst_start_addr", 32'(dec_start_addr), 32'd0);
        host_req = 1'b1;
        #1;
        chk("rst_grant_hi", 32'(host_grant), 32'd1);
        host_req = 1'b0;
        #2;
        rst_n = 1'b1;
        tick;

        // Full subframe: header 0x29A5, block 4096, order 0
        base_addr = 16'd0; block_size = 16'd4096; pred_order = 4'd0; start = 1'b1;
        tick;
        start = 1'b0;
        chk("t1_fetch_busy", 32'(busy), 32'd1);
        chk("t1_fetch_addr", 32'(ram_addr), 32'd0);
        chk("t1_fetch_decrst", 32'(dec_reset), 32'd1);
        tick;
        chk("t1_latch_en", 32'(dec_enable), 32'd0);
        tick;
        chk("t1_run_en", 32'(dec_enable), 32'd1);
        chk("t1_run_decrst", 32'(dec_reset), 32'd0);
        chk("t1_porder", 32'(dec_porder), 32'd10);
        chk("t1_start_addr", 32'(dec_start_addr), 32'd1);
        chk("t1_bs", 32'(dec_bs), 32'd4096);
        chk("t1_error", 32'(error), 32'd0);
        dec_read_addr = 16'h0005;
        #1;
        chk("t1_dec_addr", 32'(ram_addr), 32'h0005);
        valids = 0;
        dones  = 0;
        for (int unsigned i = 0; i < 4096; i++) begin
            dec_done     = 1'b1;
            dec_residual = res_val(i);
            if (i == 10) block_size = 16'd5;
            tick;
            if (valid === 1'b1) valids++;
            if (done === 1'b1) dones++;
            if (i < 4) chk($sformatf("t1_res%0d", i), 32'(residual), 32'(res_val(i)));
        end
        chk("t1_done_with_last_valid", 32'(done), 32'd0);
        tick;
        dec_done = 1'b0;
        chk("t1_late_strobe_valid", 32'(valid), 32'd0);
        chk("t1_done_pulse", 32'(done), 32'd1);
        chk("t1_early_dones", dones, 32'd0);
        tick;
        chk("t1_done_clear", 32'(done), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_valid_count", valids, 32'd4096);

        // Unsupported method 01
        start_sub(16'd8, 16'd4096, 4'd0);
        chk("t2_error", 32'(error), 32'd1);
        chk("t2_en", 32'(dec_enable), 32'd0);
        chk("t2_decrst", 32'(dec_reset), 32'd1);
        chk("t2_valid", 32'(valid), 32'd0);
        tick;
        chk("t2_idle", 32'(busy), 32'd0);
        chk("t2_sticky", 32'(error), 32'd1);

        // 4096 >> 10 = 4 <= 5; error clears on accepted start first
        base_addr = 16'd0; block_size = 16'd4096; pred_order = 4'd5; start = 1'b1;
        tick;
        start = 1'b0;
        chk("t3_err_cleared", 32'(error), 32'd0);
        tick;
        tick;
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_en", 32'(dec_enable), 32'd0);
        tick;

        // Block 4095 not divisible by 2 partitions
        start_sub(16'd16, 16'd4095, 4'd0);
        chk("t4_error", 32'(error), 32'd1);
        tick;

        // Boundary: 64 >> 3 = 8, order 8 fails and order 7 passes
        start_sub(16'd24, 16'd64, 4'd8);
        chk("t5_eq_error", 32'(error), 32'd1);
        tick;
        start_sub(16'd24, 16'd64, 4'd7);
        chk("t5_ok_error", 32'(error), 32'd0);
        chk("t5_ok_en", 32'(dec_enable), 32'd1);
        abort_req = 1'b1;
        tick;
        abort_req = 1'b0;
        chk("t5_abort_idle", 32'(busy), 32'd0);

        // Abort after 100 valids
        start_sub(16'd0, 16'd4096, 4'd3);
        feed(100, valids);
        chk("t6_valids", valids, 32'd100);
        abort_req = 1'b1;
        dec_done  = 1'b1;
        tick;
        abort_req = 1'b0;
        dec_done  = 1'b0;
        chk("t6_idle", 32'(busy), 32'd0);
        chk("t6_decrst", 32'(dec_reset), 32'd1);
        chk("t6_no_valid", 32'(valid), 32'd0);
        chk("t6_no_done", 32'(done), 32'd0);
        tick;
        chk("t6_no_done2", 32'(done), 32'd0);

        // Fresh subframe after abort: 64 samples, order 2 -> 62 residuals
        start_sub(16'd32, 16'd64, 4'd2);
        chk("t7_pred", 32'(dec_pred), 32'd2);
        chk("t7_bs", 32'(dec_bs), 32'd64);
        chk("t7_start_addr", 32'(dec_start_addr), 32'd33);
        chk("t7_porder", 32'(dec_porder), 32'd2);
        feed(62, valids);
        chk("t7_last_no_done", 32'(done), 32'd0);
        tick;
        chk("t7_done", 32'(done), 32'd1);
        chk("t7_valids", valids, 32'd62);
        tick;

        // Host arbitration, then simultaneous start
        host_req  = 1'b1;
        host_addr = 16'h0123;
        #1;
        chk("t8_grant", 32'(host_grant), 32'd1);
        chk("t8_host_addr", 32'(ram_addr), 32'h0123);
        base_addr = 16'h0040; block_size = 16'd64; pred_order = 4'd2; start = 1'b1;
        tick;
        start = 1'b0;
        chk("t8_grant_drop", 32'(host_grant), 32'd0);
        chk("t8_fetch_addr", 32'(ram_addr), 32'h0040);
        chk("t8_busy", 32'(busy), 32'd1);
        abort_req = 1'b1;
        tick;
        abort_req = 1'b0;
        chk("t8_regrant", 32'(host_grant), 32'd1);
        host_req = 1'b0;
        tick;

        // Asynchronous reset mid-RUN
        start_sub(16'd32, 16'd64, 4'd2);
        feed(5, valids);
        chk("t9_pre_valid", 32'(valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t9_busy", 32'(busy), 32'd0);
        chk("t9_valid", 32'(valid), 32'd0);
        chk("t9_residual", 32'(residual), 32'd0);
        chk("t9_decrst", 32'(dec_reset), 32'd1);
        chk("t9_en", 32'(dec_enable), 32'd0);
        chk("t9_addr", 32'(ram_addr), 32'd0);
        chk("t9_porder", 32'(dec_porder), 32'd0);
        chk("t9_done", 32'(done), 32'd0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("t9_post_done", 32'(done), 32'd0);
        chk("t9_post_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
